// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for rr_stream_mux: N input streams, arbitration controls and one output stream.
// The slave modport is the mux's view; master is the producer/consumer environment.
interface rr_stream_mux_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 2
);
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a one-entry output register.
module rr_stream_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 2
) (
  input logic            clk,
  input logic            rst_n,
  rr_stream_mux_if.slave bus
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          xfer;
  logic          fix_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;

  // ptr + off wrapped into 0..N-1; off never exceeds N so one subtraction suffices.
  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  assign load = !out_valid_q || bus.out_ready;

  // Comparing against every legal index keeps sel >= N from ever granting.
  always_comb begin
    fix_vld = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.sel == SW'(i) && bus.in_valid[i]) fix_vld = 1'b1;
    end
  end

  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!rr_vld && bus.in_valid[wrap_idx(ptr_q, k)]) begin
        rr_vld = 1'b1;
        rr_idx = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    grant_vld = bus.mode ? rr_vld : fix_vld;
    grant_idx = bus.mode ? rr_idx : bus.sel;
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) grant_data = bus.in_data[i*W +: W];
    end
  end

  // No transfer may be signalled while reset is held.
  assign xfer = rst_n && load && grant_vld;

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.in_ready[i] = xfer && (grant_idx == SW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        if (bus.mode) ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed scenarios plus random traffic, all checked against
// a transaction-level model of the arbitration rules.
module tb_rr_stream_mux;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic clk;
  logic rst_n;

  rr_stream_mux_if #(.N(N), .W(W), .SW(SW)) bus ();

  rr_stream_mux #(.N(N), .W(W), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the output register should hold and who was last served.
  int     m_ptr;
  bit     m_valid;
  int     m_data;
  int     m_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Returns the granted channel under the arbitration rules, or -1 if none.
  function automatic int model_grant();
    int s;
    if (!bus.mode) begin
      s = int'(bus.sel);
      if (s < N && bus.in_valid[s]) return s;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr   = N - 1;
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
  endfunction

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    int         g;
    bit         ld;
    logic [3:0] exp_rdy;
    #1;
    ld = !m_valid || bus.out_ready;
    g  = model_grant();
    exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = int'(bus.in_data[g*W +: W]);
        m_ch   = g;
        if (bus.mode) m_ptr = g;
      end
    end
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_ch", 32'(bus.out_ch), 32'(m_ch));
  endtask

  // Reset with whatever inputs are present; everything must read idle while held.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] held;

  initial begin
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // After release, channel 0 has first priority.
    step();
    check("first_grant", 32'(bus.out_ch), 32'd0);

    // Fixed select.
    do_reset();
    bus.mode = 1'b0;
    bus.sel  = 2'd2;
    #1;
    check("fix_in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check("fix_data", 32'(bus.out_data), 32'hC2);
    check("fix_ch", 32'(bus.out_ch), 32'd2);
    bus.in_valid = 4'b1011;
    step();
    check("fix_nogrant", 32'(bus.out_valid), 32'd0);

    // Round-robin fairness.
    do_reset();
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq", 32'(bus.out_ch), 32'(i % 4));
    end

    // Sparse round-robin, then a lone channel 0.
    do_reset();
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("sparse_seq", 32'(bus.out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    bus.in_valid = 4'b0001;
    step();
    check("sparse_ch0", 32'(bus.out_ch), 32'd0);

    // Back-pressure then release with same-cycle refill.
    do_reset();
    bus.in_valid = 4'b1111;
    step();
    held = bus.out_data;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_data", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_refill_valid", 32'(bus.out_valid), 32'd1);
    check("bp_refill_ch", 32'(bus.out_ch), 32'd1);

    // Mode switch keeps ptr; async reset mid-stream.
    do_reset();
    step();
    check("ms_ch0", 32'(bus.out_ch), 32'd0);
    step();
    check("ms_ch1", 32'(bus.out_ch), 32'd1);
    bus.mode = 1'b0;
    bus.sel  = 2'd3;
    step();
    check("ms_fix3a", 32'(bus.out_ch), 32'd3);
    step();
    check("ms_fix3b", 32'(bus.out_ch), 32'd3);
    bus.mode = 1'b1;
    step();
    check("ms_resume", 32'(bus.out_ch), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ch0", 32'(bus.out_ch), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.mode      = ($urandom_range(0, 3) != 0);
      bus.sel       = SW'($urandom_range(0, 3));
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
